timer0_controller: RTL and testbench
====================================

# timer0_controller

Clock-select, prescaler and mode sequencer for the 8-bit Timer/Counter0 of the ATmega32A emulator. It generates the count-enable tick from the system clock or the T0 pin and owns the TCNT0 count register. It applies Normal or CTC counting rules and maintains the TOV0/OCF0 interrupt flags. It sits between the I/O register file (TCCR0, TCNT0, OCR0, TIFR writes) and the interrupt controller.

## Interface
- PS_WIDTH, 10, prescaler counter width; must be ≥10 to reach /1024.
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  asynchronous, active-high reset.
- cs  in  3  clock select (TCCR0[2:0]).
- ctc  in  1  0 = Normal mode, 1 = CTC mode (clear on OCR0 match).
- t0_pin  in  1  external clock input, already synchronised to clk.
- psr  in  1  prescaler reset strobe (SFIOR.PSR10), one cycle.
- tcnt_wr  in  1  TCNT0 write strobe.
- tcnt_wdata  in  8  TCNT0 write value.
- ocr  in  8  OCR0 compare value.
- flag_clr  in  2  write-1-to-clear: [0] TOV0, [1] OCF0.
- tcnt  out  8  current TCNT0; reset 0x00.
- tov  out  1  TOV0 flag; reset 0.
- ocf  out  1  OCF0 flag; reset 0.
- tick  out  1  count-enable pulse, combinational from registered state; reset 0.

## Operation
- Prescaler: PS_WIDTH-bit free-running up-counter. Increments every clk. Wraps at 2^PS_WIDTH−1. Cleared to 0 by clr or psr.
- Tick source by cs:
  - 0: none (stopped).
  - 1: every cycle.
  - 2: prescaler[2:0]==7.
  - 3: prescaler[5:0]==63.
  - 4: prescaler[7:0]==255.
  - 5: prescaler[9:0]==1023.
  - 6: T0 falling edge.
  - 7: T0 rising edge.
- Edge detector: one register t0_prev, reset 0. Rising edge = t0_pin & ~t0_prev. Falling edge = ~t0_pin & t0_prev.
- psr asserted: tick for cs 2–5 is suppressed that cycle. cs 0, 1, 6 and 7 are unaffected.
- Counter update, in priority order:
  1. tcnt_wr: tcnt ← tcnt_wdata. Any tick that cycle is discarded. Sets block_cmp.
  2. tick, block_cmp=0, tcnt==ocr:
     - Sets ocf.
     - CTC: tcnt ← 0.
     - Normal: tcnt ← tcnt+1.
  3. tick otherwise: tcnt ← tcnt+1, 8-bit wrap. Clears block_cmp.
- tov is set on any tick where tcnt transitions 0xFF→0x00.
  - CTC with ocr=0xFF: both ocf and tov are set on the same tick.
  - CTC with ocr<0xFF: tov is never set unless tcnt was written above ocr and counts through 0xFF.
- block_cmp: one-tick compare suppression after a TCNT0 write. Reset 0.
  - Cleared on the next tick, whether or not that tick matched.
  - A blocked match does not set ocf and does not clear tcnt in CTC mode; tcnt increments instead.
- Flags are sticky.
  - flag_clr bit clears the matching flag.
  - If set and clear occur in the same cycle, set wins.
- A cs change takes effect on the next cycle. The prescaler is not reset by a cs change.

## Timing
- tcnt, tov and ocf change on the clk edge that ends the tick cycle. Tick-to-output latency is 1 cycle.
- cs=1: tcnt increments every clk.
- cs=2 after clr release: first tick in the cycle where prescaler==7. tcnt==1 after the 8th edge, then +1 every 8 edges.
- T0 edge: the pin change is seen on tcnt 1 cycle after t0_pin is sampled changed. Pulses shorter than 1 clk are lost; the pin is pre-synchronised.
- clr mid-operation: all registers return to their reset values immediately, including the prescaler, t0_prev and block_cmp. Counting resumes from 0 on the first edge after release.

## Structure
- Shared package timer0_pkg:
  - cs encodings as localparams: CS_STOP, CS_DIV1, CS_DIV8, CS_DIV64, CS_DIV256, CS_DIV1024, CS_EXT_FALL, CS_EXT_RISE.
  - Flag bit indices: TOV_BIT, OCF_BIT.
- Sub-module timer0_prescaler holds the prescaler counter, the tick select mux and the T0 edge detector. Outputs: tick.
- The top level holds tcnt, block_cmp and the flag logic. Storage uses the team's multi-bit enabled flip-flop block where convenient.

## Test plan
- cs=1, Normal, ocr=0x10, from reset: after 16 edges tcnt=0x10; ocf set on the 17th edge, tcnt=0x11; tov set on the 256th edge, tcnt=0x00.
- cs=1, CTC, ocr=0x04: tcnt sequence 0,1,2,3,4,0,1…; ocf set each time 4→0; tov never set; flag_clr=2'b10 with no match clears ocf next edge.
- cs=3 (/64): tcnt=1 exactly after 64 edges. psr pulse at edge 40: next tick at edge 104, tcnt=1 until then. Switching to cs=0 freezes tcnt.
- cs=7, toggle t0_pin every 5 cycles: tcnt increments once per rising edge, 1 cycle after the pin is sampled high. cs=6 counts falling edges only.
- cs=1, ocr=0x20: tcnt_wr=1 with tcnt_wdata=0x20 on the same cycle as a tick → tcnt=0x20, no increment. Next tick: no ocf, tcnt=0x21.
- tcnt=0xFF with a tick and flag_clr=2'b01 in the same cycle → tov=1 (set wins). Assert clr mid-count → all outputs 0 asynchronously.

Source files
------------

// File: rtl/timer0_pkg.sv
// Timer/Counter0 shared definitions: clock-select codes and flag bit indices.
// Imported by the prescaler, the interface users and the controller top.
package timer0_pkg;

  localparam logic [2:0] CS_STOP     = 3'd0;
  localparam logic [2:0] CS_DIV1     = 3'd1;
  localparam logic [2:0] CS_DIV8     = 3'd2;
  localparam logic [2:0] CS_DIV64    = 3'd3;
  localparam logic [2:0] CS_DIV256   = 3'd4;
  localparam logic [2:0] CS_DIV1024  = 3'd5;
  localparam logic [2:0] CS_EXT_FALL = 3'd6;
  localparam logic [2:0] CS_EXT_RISE = 3'd7;

  localparam int TOV_BIT = 0;
  localparam int OCF_BIT = 1;

  localparam int PS_WIDTH_MIN = 10;

endpackage

// File: rtl/timer0_controller_if.sv
// Register-file side bundle of Timer0: TCCR0/TCNT0/OCR0/TIFR controls in,
// count value, flags and tick out. master = register file, slave = timer.
interface timer0_controller_if;

  logic [2:0] cs;
  logic       ctc;
  logic       t0_pin;
  logic       psr;
  logic       tcnt_wr;
  logic [7:0] tcnt_wdata;
  logic [7:0] ocr;
  logic [1:0] flag_clr;
  logic [7:0] tcnt;
  logic       tov;
  logic       ocf;
  logic       tick;

  modport master (
    output cs, ctc, t0_pin, psr,
    output tcnt_wr, tcnt_wdata, ocr, flag_clr,
    input  tcnt, tov, ocf, tick
  );

  modport slave (
    input  cs, ctc, t0_pin, psr,
    input  tcnt_wr, tcnt_wdata, ocr, flag_clr,
    output tcnt, tov, ocf, tick
  );

endinterface

// File: rtl/timer0_prescaler.sv
// Free-running prescaler, T0 edge detector and clock-select tick mux.
// Ports: clk, clr (async high), cs, psr, t0_pin in; tick out.
module timer0_prescaler
  import timer0_pkg::*;
#(
  parameter int PS_WIDTH = 10
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [2:0] cs,
  input  logic       psr,
  input  logic       t0_pin,
  output logic       tick
);

  logic [PS_WIDTH-1:0] ps;
  logic                t0_prev;
  logic                sel;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ps      <= '0;
      t0_prev <= 1'b0;
    end else begin
      ps      <= psr ? '0 : ps + 1'b1;
      t0_prev <= t0_pin;
    end
  end

  // A prescaler reset kills this cycle's divided tick so the
  // next one lands a full period after the strobe.
  always_comb begin
    sel = 1'b0;
    unique case (cs)
      CS_STOP:     sel = 1'b0;
      CS_DIV1:     sel = 1'b1;
      CS_DIV8:     sel = !psr && (&ps[2:0]);
      CS_DIV64:    sel = !psr && (&ps[5:0]);
      CS_DIV256:   sel = !psr && (&ps[7:0]);
      CS_DIV1024:  sel = !psr && (&ps[9:0]);
      CS_EXT_FALL: sel = !t0_pin && t0_prev;
      CS_EXT_RISE: sel = t0_pin && !t0_prev;
    endcase
  end

  assign tick = sel & ~clr;

endmodule

// File: rtl/timer0_controller.sv
// Timer/Counter0 core: TCNT0, one-tick compare block after writes, TOV0/OCF0.
// Ports: clk, clr (async high) plain; everything else via bus (slave).
module timer0_controller
  import timer0_pkg::*;
#(
  parameter int PS_WIDTH = 10
) (
  input logic                clk,
  input logic                clr,
  timer0_controller_if.slave bus
);

  logic       tick;
  logic [7:0] tcnt_q;
  logic [7:0] tcnt_d;
  logic       block_q;
  logic       block_d;
  logic       tov_q;
  logic       ocf_q;
  logic       tov_set;
  logic       ocf_set;

  timer0_prescaler #(
    .PS_WIDTH (PS_WIDTH)
  ) u_ps (
    .clk    (clk),
    .clr    (clr),
    .cs     (bus.cs),
    .psr    (bus.psr),
    .t0_pin (bus.t0_pin),
    .tick   (tick)
  );

  // A write owns the cycle; a blocked match just counts on.
  // Both the CTC clear and the increment leave 0xFF at 0x00,
  // so overflow only depends on the old count.
  always_comb begin
    tcnt_d  = tcnt_q;
    block_d = block_q;
    tov_set = 1'b0;
    ocf_set = 1'b0;
    if (bus.tcnt_wr) begin
      tcnt_d  = bus.tcnt_wdata;
      block_d = 1'b1;
    end else if (tick) begin
      block_d = 1'b0;
      tov_set = (tcnt_q == 8'hFF);
      if (!block_q && tcnt_q == bus.ocr) begin
        ocf_set = 1'b1;
        tcnt_d  = bus.ctc ? 8'h00 : tcnt_q + 8'd1;
      end else begin
        tcnt_d  = tcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      tcnt_q  <= 8'h00;
      block_q <= 1'b0;
      tov_q   <= 1'b0;
      ocf_q   <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      block_q <= block_d;
      tov_q   <= tov_set |
                 (tov_q & ~bus.flag_clr[TOV_BIT]);
      ocf_q   <= ocf_set |
                 (ocf_q & ~bus.flag_clr[OCF_BIT]);
    end
  end

  assign bus.tcnt = tcnt_q;
  assign bus.tov  = tov_q;
  assign bus.ocf  = ocf_q;
  assign bus.tick = tick;

endmodule

// File: tb/tb_timer0_controller.sv
// Self-checking bench for timer0_controller: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_timer0_controller;
  import timer0_pkg::*;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  timer0_controller_if bus();

  timer0_controller #(
    .PS_WIDTH (10)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  int         m_ps;
  bit         m_prev;
  logic [7:0] m_tcnt;
  bit         m_tov;
  bit         m_ocf;
  bit         m_block;

  function automatic bit m_tick();
    int div;
    if (clr) return 1'b0;
    case (bus.cs)
      3'd0: return 1'b0;
      3'd1: return 1'b1;
      3'd2: div = 8;
      3'd3: div = 64;
      3'd4: div = 256;
      3'd5: div = 1024;
      3'd6: return !bus.t0_pin && m_prev;
      default: return bus.t0_pin && !m_prev;
    endcase
    return !bus.psr && ((m_ps % div) == div - 1);
  endfunction

  task automatic m_reset();
    m_ps = 0; m_prev = 0; m_tcnt = 8'h00;
    m_tov = 0; m_ocf = 0; m_block = 0;
  endtask

  // Advance one clock: model next state from the inputs held
  // during this cycle, then step past the edge.
  task automatic cycle();
    bit         tk, nb, ts, os, ntov, nocf, nprev;
    logic [7:0] nt;
    int         nps;
    tk = m_tick();
    nt = m_tcnt; nb = m_block; ts = 0; os = 0;
    if (bus.tcnt_wr) begin
      nt = bus.tcnt_wdata;
      nb = 1;
    end else if (tk) begin
      nb = 0;
      if (!m_block && m_tcnt == bus.ocr) begin
        os = 1;
        nt = bus.ctc ? 8'h00 : m_tcnt + 8'd1;
      end else begin
        nt = m_tcnt + 8'd1;
      end
      ts = (m_tcnt == 8'hFF) && (nt == 8'h00);
    end
    ntov  = ts || (m_tov && !bus.flag_clr[0]);
    nocf  = os || (m_ocf && !bus.flag_clr[1]);
    nps   = bus.psr ? 0 : (m_ps + 1) % 1024;
    nprev = bus.t0_pin;
    @(posedge clk);
    m_tcnt = nt; m_block = nb; m_tov = ntov;
    m_ocf = nocf; m_ps = nps; m_prev = nprev;
    #1;
  endtask

  task automatic idle_inputs();
    bus.cs = CS_STOP; bus.ctc = 0; bus.t0_pin = 0;
    bus.psr = 0; bus.tcnt_wr = 0; bus.tcnt_wdata = 0;
    bus.ocr = 0; bus.flag_clr = 0;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    m_reset();
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.cs = CS_DIV1;
    clr = 1'b1;
    #2;
    checks++;
    if (bus.tcnt !== 8'h00) begin
      failures++;
      $display("FAIL reset_tcnt got=%h want=00", bus.tcnt);
    end
    checks++;
    if (bus.tov !== 1'b0 || bus.ocf !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got tov=%b ocf=%b want 0 0",
               bus.tov, bus.ocf);
    end
    checks++;
    if (bus.tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_tick got=%b want=0", bus.tick);
    end
    do_reset();
  endtask

  task automatic test_normal();
    idle_inputs();
    bus.cs = CS_DIV1; bus.ocr = 8'h10;
    do_reset();
    repeat (16) cycle();
    checks++;
    if (bus.tcnt !== 8'h10 || bus.ocf !== 1'b0) begin
      failures++;
      $display("FAIL normal_e16 got tcnt=%h ocf=%b want 10 0",
               bus.tcnt, bus.ocf);
    end
    cycle();
    checks++;
    if (bus.tcnt !== 8'h11 || bus.ocf !== 1'b1) begin
      failures++;
      $display("FAIL normal_e17 got tcnt=%h ocf=%b want 11 1",
               bus.tcnt, bus.ocf);
    end
    repeat (238) cycle();
    checks++;
    if (bus.tcnt !== 8'hFF || bus.tov !== 1'b0) begin
      failures++;
      $display("FAIL normal_e255 got tcnt=%h tov=%b want ff 0",
               bus.tcnt, bus.tov);
    end
    cycle();
    checks++;
    if (bus.tcnt !== 8'h00 || bus.tov !== 1'b1) begin
      failures++;
      $display("FAIL normal_e256 got tcnt=%h tov=%b want 00 1",
               bus.tcnt, bus.tov);
    end
  endtask

  task automatic test_ctc();
    idle_inputs();
    bus.cs = CS_DIV1; bus.ctc = 1; bus.ocr = 8'h04;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      cycle();
      checks++;
      if (bus.tcnt !== 8'(k % 5) || bus.ocf !== (k >= 5)
          || bus.tov !== 1'b0) begin
        failures++;
        $display("FAIL ctc_seq e%0d got tcnt=%h ocf=%b tov=%b",
                 k, bus.tcnt, bus.ocf, bus.tov);
      end
    end
    bus.flag_clr = 2'b10;
    cycle();
    bus.flag_clr = 2'b00;
    checks++;
    if (bus.ocf !== 1'b0 || bus.tcnt !== 8'h01) begin
      failures++;
      $display("FAIL ctc_ocf_clr got ocf=%b tcnt=%h want 0 01",
               bus.ocf, bus.tcnt);
    end
  endtask

  task automatic test_prescale();
    logic [7:0] frozen;
    idle_inputs();
    bus.cs = CS_DIV64;
    do_reset();
    repeat (63) cycle();
    checks++;
    if (bus.tcnt !== 8'h00) begin
      failures++;
      $display("FAIL div64_e63 got=%h want=00", bus.tcnt);
    end
    cycle();
    checks++;
    if (bus.tcnt !== 8'h01) begin
      failures++;
      $display("FAIL div64_e64 got=%h want=01", bus.tcnt);
    end
    do_reset();
    repeat (39) cycle();
    bus.psr = 1;
    cycle();
    bus.psr = 0;
    repeat (63) cycle();
    checks++;
    if (bus.tcnt !== 8'h00) begin
      failures++;
      $display("FAIL psr_e103 got=%h want=00", bus.tcnt);
    end
    cycle();
    checks++;
    if (bus.tcnt !== 8'h01) begin
      failures++;
      $display("FAIL psr_e104 got=%h want=01", bus.tcnt);
    end
    frozen = bus.tcnt;
    bus.cs = CS_STOP;
    repeat (200) cycle();
    checks++;
    if (bus.tcnt !== 8'h01 || bus.tick !== 1'b0) begin
      failures++;
      $display("FAIL stop_freeze got tcnt=%h tick=%b want %h 0",
               bus.tcnt, bus.tick, frozen);
    end
  endtask

  task automatic test_ext_clock();
    for (int mode = 0; mode < 2; mode++) begin
      int rises = 0;
      int falls = 0;
      idle_inputs();
      bus.cs = (mode == 0) ? CS_EXT_RISE : CS_EXT_FALL;
      do_reset();
      for (int i = 0; i < 60; i++) begin
        if (i % 5 == 0) begin
          bus.t0_pin = ~bus.t0_pin;
          if (bus.t0_pin) rises++;
          else falls++;
        end
        cycle();
        checks++;
        if (bus.tcnt !== 8'((mode == 0) ? rises : falls)) begin
          failures++;
          $display("FAIL ext_cs%0d i=%0d got=%h want=%h",
                   bus.cs, i, bus.tcnt,
                   (mode == 0) ? rises : falls);
        end
      end
    end
  endtask

  task automatic test_write_block();
    idle_inputs();
    bus.cs = CS_DIV1; bus.ocr = 8'h20;
    do_reset();
    repeat (5) cycle();
    bus.tcnt_wr = 1; bus.tcnt_wdata = 8'h20;
    cycle();
    bus.tcnt_wr = 0;
    checks++;
    if (bus.tcnt !== 8'h20 || bus.ocf !== 1'b0) begin
      failures++;
      $display("FAIL wr_tick got tcnt=%h ocf=%b want 20 0",
               bus.tcnt, bus.ocf);
    end
    cycle();
    checks++;
    if (bus.tcnt !== 8'h21 || bus.ocf !== 1'b0) begin
      failures++;
      $display("FAIL wr_block got tcnt=%h ocf=%b want 21 0",
               bus.tcnt, bus.ocf);
    end
    repeat (256) cycle();
    checks++;
    if (bus.tcnt !== 8'h21 || bus.ocf !== 1'b1) begin
      failures++;
      $display("FAIL wr_unblock got tcnt=%h ocf=%b want 21 1",
               bus.tcnt, bus.ocf);
    end
  endtask

  task automatic test_tov_setwins();
    idle_inputs();
    bus.cs = CS_DIV1;
    do_reset();
    bus.tcnt_wr = 1; bus.tcnt_wdata = 8'hFF;
    cycle();
    bus.tcnt_wr = 0;
    bus.flag_clr = 2'b01;
    cycle();
    checks++;
    if (bus.tov !== 1'b1 || bus.tcnt !== 8'h00) begin
      failures++;
      $display("FAIL tov_setwins got tov=%b tcnt=%h want 1 00",
               bus.tov, bus.tcnt);
    end
    cycle();
    bus.flag_clr = 2'b00;
    checks++;
    if (bus.tov !== 1'b0) begin
      failures++;
      $display("FAIL tov_clr got=%b want=0", bus.tov);
    end
  endtask

  task automatic test_clr_mid();
    idle_inputs();
    bus.cs = CS_DIV1;
    do_reset();
    bus.tcnt_wr = 1; bus.tcnt_wdata = 8'hFF;
    cycle();
    bus.tcnt_wr = 0;
    repeat (4) cycle();
    checks++;
    if (bus.tcnt !== 8'h03 || bus.tov !== 1'b1
        || bus.ocf !== 1'b1) begin
      failures++;
      $display("FAIL clr_pre got tcnt=%h tov=%b ocf=%b want 03 1 1",
               bus.tcnt, bus.tov, bus.ocf);
    end
    #3;
    clr = 1'b1;
    #1;
    checks++;
    if (bus.tcnt !== 8'h00 || bus.tov !== 1'b0
        || bus.ocf !== 1'b0 || bus.tick !== 1'b0) begin
      failures++;
      $display("FAIL clr_async got tcnt=%h tov=%b ocf=%b tick=%b",
               bus.tcnt, bus.tov, bus.ocf, bus.tick);
    end
    m_reset();
    @(posedge clk);
    #1;
    clr = 1'b0;
    cycle();
    checks++;
    if (bus.tcnt !== 8'h01) begin
      failures++;
      $display("FAIL clr_resume got=%h want=01", bus.tcnt);
    end
  endtask

  task automatic test_random();
    int shown = 0;
    idle_inputs();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i % 150 == 0) begin
        bus.cs  = 3'($urandom_range(0, 7));
        bus.ctc = 1'($urandom_range(0, 1));
        bus.ocr = ($urandom_range(0, 3) == 0)
                  ? 8'($urandom_range(0, 255))
                  : 8'($urandom_range(0, 12));
      end
      if ($urandom_range(0, 3) == 0) bus.t0_pin = ~bus.t0_pin;
      bus.psr = ($urandom_range(0, 40) == 0);
      bus.tcnt_wr = ($urandom_range(0, 30) == 0);
      bus.tcnt_wdata = ($urandom_range(0, 1) == 0)
                       ? bus.ocr : 8'($urandom_range(0, 255));
      bus.flag_clr = ($urandom_range(0, 7) == 0)
                     ? 2'($urandom_range(0, 3)) : 2'b00;
      #1;
      checks++;
      if (bus.tick !== m_tick()) begin
        failures++;
        if (shown++ < 10)
          $display("FAIL rnd_tick i=%0d got=%b want=%b",
                   i, bus.tick, m_tick());
      end
      cycle();
      checks++;
      if (bus.tcnt !== m_tcnt || bus.tov !== m_tov
          || bus.ocf !== m_ocf) begin
        failures++;
        if (shown++ < 10)
          $display("FAIL rnd_state i=%0d got %h/%b/%b want %h/%b/%b",
                   i, bus.tcnt, bus.tov, bus.ocf,
                   m_tcnt, m_tov, m_ocf);
      end
    end
  endtask

  initial begin
    clr = 1'b1;
    idle_inputs();
    m_reset();
    #1;
    test_reset();
    test_normal();
    test_ctc();
    test_prescale();
    test_ext_clock();
    test_write_block();
    test_tov_setwins();
    test_clr_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
